gpu_cmd_sequencer: RTL and testbench

APB-facing command front end for the GPU. Captures 32-bit command words written over APB into a small FIFO, decodes them, holds the endpoint registers, and sequences the line rasterizer through a start/done handshake. It sits between the APB slave pins of `gpu` and the rasterizer datapath that drives `x_o/y_o/r_o/g_o/b_o`. Commands queue while a line is drawing, so software never waits on the rasterizer.

---
 rtl/gpu_pkg.sv | 31 +++
 rtl/gpu_cmd_sequencer_if.sv | 19 +
 rtl/gpu_cmd_fifo.sv | 46 ++++
 rtl/gpu_cmd_sequencer.sv | 117 +++++++++++
 tb/tb_gpu_cmd_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared types and field positions for the GPU command front end.
package gpu_pkg;

  localparam int CMD_W     = 32;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int COLOR_W   = 24;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 28;
  localparam int X_MSB     = 18;
  localparam int X_LSB     = 9;
  localparam int Y_MSB     = 8;
  localparam int Y_LSB     = 0;
  localparam int COLOR_MSB = 23;
  localparam int COLOR_LSB = 0;

  typedef enum logic [3:0] {
    SET_XY1   = 4'h1,
    SET_XY2   = 4'h2,
    DRAW_LINE = 4'h4,
    CLR_ERR   = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/gpu_cmd_sequencer_if.sv
// APB write-side signals seen by the command sequencer.
interface gpu_cmd_sequencer_if;
  import gpu_pkg::*;

  logic [31:0]    pAddr_i;
  logic [CMD_W-1:0] pDataWrite_i;
  logic           pSel_i;
  logic           pEnable_i;
  logic           pWrite_i;

  modport master (
    output pAddr_i, pDataWrite_i, pSel_i, pEnable_i, pWrite_i
  );

  modport slave (
    input pAddr_i, pDataWrite_i, pSel_i, pEnable_i, pWrite_i
  );

endinterface

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO; extra pointer MSB distinguishes full from empty.
module gpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gpu_cmd_sequencer.sv
// APB command capture, command FIFO and the rasterizer start/done sequencer.
module gpu_cmd_sequencer
  import gpu_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] CMD_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 n_rst,
  gpu_cmd_sequencer_if.slave   apb,
  output logic [X_W-1:0]       x1_o,
  output logic [Y_W-1:0]       y1_o,
  output logic [X_W-1:0]       x2_o,
  output logic [Y_W-1:0]       y2_o,
  output logic [COLOR_W-1:0]   color_o,
  output logic                 draw_start_o,
  input  logic                 draw_done_i,
  output logic                 busy_o,
  output logic                 full_o,
  output logic                 overflow_o,
  output logic                 bad_cmd_o
);

  seq_state_t       state;
  logic [CMD_W-1:0] cmd_q;
  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             acc_raw;
  logic             acc_q;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             unused_rsvd;

  // A held access phase must push only once, so accept on the rising edge of the condition.
  assign acc_raw = apb.pSel_i && apb.pEnable_i && apb.pWrite_i && (apb.pAddr_i == CMD_ADDR);
  assign push    = acc_raw && !acc_q;
  assign pop     = (state == IDLE) && !fifo_empty;
  assign ovf_set = push && fifo_full && !pop;

  assign busy_o      = !fifo_empty || (state != IDLE);
  assign full_o      = fifo_full;
  assign unused_rsvd = ^cmd_q[27:24];

  gpu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .pop   (pop),
    .wdata (apb.pDataWrite_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      cmd_q        <= '0;
      acc_q        <= 1'b0;
      x1_o         <= '0;
      y1_o         <= '0;
      x2_o         <= '0;
      y2_o         <= '0;
      color_o      <= '0;
      draw_start_o <= 1'b0;
      overflow_o   <= 1'b0;
      bad_cmd_o    <= 1'b0;
    end else begin
      acc_q        <= acc_raw;
      draw_start_o <= 1'b0;
      if (ovf_set) overflow_o <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            cmd_q <= fifo_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= IDLE;
          case (cmd_q[OPC_MSB:OPC_LSB])
            SET_XY1: begin
              x1_o <= cmd_q[X_MSB:X_LSB];
              y1_o <= cmd_q[Y_MSB:Y_LSB];
            end
            SET_XY2: begin
              x2_o <= cmd_q[X_MSB:X_LSB];
              y2_o <= cmd_q[Y_MSB:Y_LSB];
            end
            DRAW_LINE: begin
              color_o      <= cmd_q[COLOR_MSB:COLOR_LSB];
              draw_start_o <= 1'b1;
              state        <= WAIT;
            end
            CLR_ERR: begin
              // A drop in this very cycle is a fresh event and survives the clear.
              overflow_o <= ovf_set;
              bad_cmd_o  <= 1'b0;
            end
            default: bad_cmd_o <= 1'b1;
          endcase
        end
        WAIT: begin
          if (draw_done_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Directed bench for gpu_cmd_sequencer with hand-computed expectations.
module tb_gpu_cmd_sequencer;

  logic        tb_clk = 1'b0;
  logic        n_rst  = 1'b1;
  logic        draw_done_i;
  logic [9:0]  x1_o, x2_o;
  logic [8:0]  y1_o, y2_o;
  logic [23:0] color_o;
  logic        draw_start_o, busy_o, full_o, overflow_o, bad_cmd_o;

  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;
  int base;

  gpu_cmd_sequencer_if apb_if ();

  gpu_cmd_sequencer #(
    .FIFO_DEPTH (4),
    .CMD_ADDR   (32'h0000_0000)
  ) dut (
    .clk          (tb_clk),
    .n_rst        (n_rst),
    .apb          (apb_if),
    .x1_o         (x1_o),
    .y1_o         (y1_o),
    .x2_o         (x2_o),
    .y2_o         (y2_o),
    .color_o      (color_o),
    .draw_start_o (draw_start_o),
    .draw_done_i  (draw_done_i),
    .busy_o       (busy_o),
    .full_o       (full_o),
    .overflow_o   (overflow_o),
    .bad_cmd_o    (bad_cmd_o)
  );

  always #5 tb_clk = ~tb_clk;

  always @(posedge tb_clk) if (draw_start_o) start_cnt++;

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    apb_if.pSel_i       = 1'b1;
    apb_if.pWrite_i     = 1'b1;
    apb_if.pAddr_i      = addr;
    apb_if.pDataWrite_i = data;
    apb_if.pEnable_i    = 1'b0;
    step();
    apb_if.pEnable_i    = 1'b1;
    step();
    apb_if.pSel_i       = 1'b0;
    apb_if.pEnable_i    = 1'b0;
    apb_if.pWrite_i     = 1'b0;
  endtask

  task automatic pulse_done();
    draw_done_i = 1'b1;
    step();
    draw_done_i = 1'b0;
  endtask

  initial begin
    apb_if.pSel_i = 0; apb_if.pEnable_i = 0; apb_if.pWrite_i = 0;
    apb_if.pAddr_i = '0; apb_if.pDataWrite_i = '0;
    draw_done_i = 0;

    // Reset state
    #1 n_rst = 1'b0;
    repeat (3) step();
    check("rst_x1", 32'(x1_o), 0);
    check("rst_y2", 32'(y2_o), 0);
    check("rst_color", 32'(color_o), 0);
    check("rst_start", 32'(draw_start_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_full", 32'(full_o), 0);
    check("rst_flags", 32'({overflow_o, bad_cmd_o}), 0);
    n_rst = 1'b1;
    step();

    // Basic sequence: SET_XY1, SET_XY2, DRAW_LINE
    base = start_cnt;
    apb_write(32'h0, 32'h1000_0000);
    apb_write(32'h0, 32'h2000_1807);
    apb_write(32'h0, 32'h40AA_BD3E);
    step();
    check("t1_start_early", 32'(draw_start_o), 0);
    step();
    check("t1_start", 32'(draw_start_o), 1);
    check("t1_x1", 32'(x1_o), 0);
    check("t1_y1", 32'(y1_o), 0);
    check("t1_x2", 32'(x2_o), 12);
    check("t1_y2", 32'(y2_o), 7);
    check("t1_color", 32'(color_o), 32'hAABD3E);
    step();
    check("t1_start_one_cycle", 32'(draw_start_o), 0);
    repeat (8) step();
    check("t1_busy_wait", 32'(busy_o), 1);
    pulse_done();
    check("t1_busy_fall", 32'(busy_o), 0);
    check("t1_start_count", 32'(start_cnt - base), 1);

    // SET_XY1 queued behind a draw must not disturb the endpoints
    apb_write(32'h0, 32'h4012_3456);
    apb_write(32'h0, 32'h1000_0A05);
    repeat (3) step();
    check("t2_color", 32'(color_o), 32'h123456);
    check("t2_x1_hold", 32'(x1_o), 0);
    check("t2_y1_hold", 32'(y1_o), 0);
    check("t2_busy", 32'(busy_o), 1);
    pulse_done();
    step();
    check("t2_x1_still", 32'(x1_o), 0);
    step();
    check("t2_x1", 32'(x1_o), 5);
    check("t2_y1", 32'(y1_o), 5);

    // Access phase held for 5 cycles pushes once
    base = start_cnt;
    apb_if.pSel_i = 1; apb_if.pWrite_i = 1; apb_if.pAddr_i = 32'h0;
    apb_if.pDataWrite_i = 32'h4000_FF00; apb_if.pEnable_i = 0;
    step();
    apb_if.pEnable_i = 1;
    repeat (5) step();
    apb_if.pSel_i = 0; apb_if.pEnable_i = 0; apb_if.pWrite_i = 0;
    step();
    check("t3_color", 32'(color_o), 32'h00FF00);
    pulse_done();
    repeat (4) step();
    check("t3_busy", 32'(busy_o), 0);
    check("t3_single_push", 32'(start_cnt - base), 1);

    // Overflow while the rasterizer is stalled
    apb_write(32'h0, 32'h4000_0001);
    apb_write(32'h0, 32'h1000_0201);
    apb_write(32'h0, 32'h2000_0402);
    apb_write(32'h0, 32'h1000_0603);
    apb_write(32'h0, 32'h4000_C0DE);
    check("t4_full", 32'(full_o), 1);
    check("t4_no_ovf_yet", 32'(overflow_o), 0);
    apb_write(32'h0, 32'h2000_0804);
    check("t4_ovf", 32'(overflow_o), 1);
    check("t4_full_stays", 32'(full_o), 1);
    pulse_done();
    step();
    check("t4_not_full", 32'(full_o), 0);
    step();
    check("t4_q1_x1", 32'(x1_o), 1);
    check("t4_q1_y1", 32'(y1_o), 1);
    step(); step();
    check("t4_q2_x2", 32'(x2_o), 2);
    check("t4_q2_y2", 32'(y2_o), 2);
    step(); step();
    check("t4_q3_x1", 32'(x1_o), 3);
    step(); step();
    check("t4_q4_start", 32'(draw_start_o), 1);
    check("t4_q4_color", 32'(color_o), 32'h00C0DE);
    pulse_done();
    step();
    check("t4_dropped_x2", 32'(x2_o), 2);
    check("t4_busy", 32'(busy_o), 0);
    apb_write(32'h0, 32'hF000_0000);
    step(); step();
    check("t4_clr_ovf", 32'(overflow_o), 0);

    // Undefined opcode, then a write to a non-command address
    base = start_cnt;
    apb_write(32'h0, 32'h3000_0000);
    step(); step();
    check("t5_bad", 32'(bad_cmd_o), 1);
    check("t5_x1", 32'(x1_o), 3);
    check("t5_x2", 32'(x2_o), 2);
    apb_write(32'h4, 32'h4000_0001);
    repeat (3) step();
    check("t5_other_addr_busy", 32'(busy_o), 0);
    check("t5_no_start", 32'(start_cnt - base), 0);

    // Reset while drawing with two words queued
    apb_write(32'h0, 32'h4055_5555);
    apb_write(32'h0, 32'h1000_0A05);
    apb_write(32'h0, 32'h2000_0A05);
    check("t6_busy_before", 32'(busy_o), 1);
    #2 n_rst = 1'b0;
    #1;
    check("t6_rst_x1", 32'(x1_o), 0);
    check("t6_rst_x2", 32'(x2_o), 0);
    check("t6_rst_color", 32'(color_o), 0);
    check("t6_rst_flags", 32'({overflow_o, bad_cmd_o, draw_start_o}), 0);
    check("t6_rst_busy", 32'(busy_o), 0);
    step();
    n_rst = 1'b1;
    base = start_cnt;
    repeat (10) step();
    check("t6_no_start", 32'(start_cnt - base), 0);
    check("t6_idle", 32'(busy_o), 0);
    check("t6_x1_zero", 32'(x1_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
